// File: rtl/mem_bank_arbiter_if.sv
// Request/grant bundle between four requesters and the memory-bank arbiter.
// The arbiter takes the slave modport. Requesters or a testbench take the master modport.
interface mem_bank_arbiter_if;
  logic [3:0]  req;
  logic [15:0] req_bank;
  logic [3:0]  req_we;
  logic [3:0]  gnt;
  logic [3:0]  bank_sel;
  logic [15:0] bank_en;
  logic        mem_we;
  logic        busy;
  logic [3:0]  done;

  modport slave (
    input  req, req_bank, req_we,
    output gnt, bank_sel, bank_en, mem_we, busy, done
  );

  modport master (
    output req, req_bank, req_we,
    input  gnt, bank_sel, bank_en, mem_we, busy, done
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter that gives one of four requesters a single bank access per transaction.
// Each transaction runs IDLE -> GRANT -> ACCESS (ACCESS_CYCLES long) -> DONE.
module mem_bank_arbiter #(
  parameter int ACCESS_CYCLES = 2  // legal range 1..15
) (
  input  logic               clk,
  input  logic               clr,
  mem_bank_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] id_q,    id_d;
  logic [3:0] bank_q,  bank_d;
  logic       we_q,    we_d;
  logic [3:0] cnt_q,   cnt_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic [3:0] id_onehot;

  // Winner is the first requester at or above ptr, wrapping modulo 4.
  always_comb begin
    winner = ptr_q;
    idx    = '0;
    found  = 1'b0;
    for (int off = 0; off < 4; off++) begin
      idx = ptr_q + 2'(off);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      bank_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    bank_d  = bank_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          id_d    = winner;
          bank_d  = bus.req_bank[{winner, 2'b00} +: 4];
          we_d    = bus.req_we[winner];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ptr_d   = id_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign id_onehot    = 4'b0001 << id_q;
  assign bus.bank_sel = bank_q;

  // Outputs decode from registered state only, so an asynchronous clear zeroes them at once.
  always_comb begin
    bus.gnt     = '0;
    bus.bank_en = '0;
    bus.mem_we  = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = '0;
    unique case (state_q)
      S_IDLE: ;
      S_GRANT: begin
        bus.gnt  = id_onehot;
        bus.busy = 1'b1;
      end
      S_ACCESS: begin
        bus.gnt     = id_onehot;
        bus.busy    = 1'b1;
        bus.bank_en = 16'h0001 << bank_q;
        bus.mem_we  = we_q;
      end
      S_DONE: begin
        bus.gnt  = id_onehot;
        bus.busy = 1'b1;
        bus.done = id_onehot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Self-checking bench for mem_bank_arbiter: a scoreboard of per-cycle output snapshots,
// table-driven arbitration vectors, and hand-written reset and parameter-sweep sequences.
module tb_mem_bank_arbiter;

  localparam int AC = 2;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [3:0]  bank_sel;
    logic [15:0] bank_en;
    logic        mem_we;
    logic        busy;
    logic [3:0]  done;
  } snap_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] req_bank;
    logic [3:0]  req_we;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_bank;
    logic        exp_we;
  } vec_t;

  logic clk;
  logic clr;

  mem_bank_arbiter_if bus   ();
  mem_bank_arbiter_if bus1  ();
  mem_bank_arbiter_if bus15 ();

  mem_bank_arbiter #(.ACCESS_CYCLES(AC)) dut (.clk(clk), .clr(clr), .bus(bus.slave));
  mem_bank_arbiter #(.ACCESS_CYCLES(1))  dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));
  mem_bank_arbiter #(.ACCESS_CYCLES(15)) dut15 (.clk(clk), .clr(clr), .bus(bus15.slave));

  int    n_cmp  = 0;
  int    n_fail = 0;
  snap_t sb_q[$];
  vec_t  vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t snap();
    return {bus.gnt, bus.bank_sel, bus.bank_en, bus.mem_we, bus.busy, bus.done};
  endfunction

  task automatic drive(input logic [3:0] r, input logic [15:0] rb, input logic [3:0] rw);
    bus.req   = r;  bus.req_bank   = rb; bus.req_we   = rw;
    bus1.req  = r;  bus1.req_bank  = rb; bus1.req_we  = rw;
    bus15.req = r;  bus15.req_bank = rb; bus15.req_we = rw;
  endtask

  task automatic check(input string name, input snap_t act, input snap_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b sel=%h en=%h we=%b busy=%b done=%b, want gnt=%b sel=%h en=%h we=%b busy=%b done=%b",
               name, act.gnt, act.bank_sel, act.bank_en, act.mem_we, act.busy, act.done,
               exp.gnt, exp.bank_sel, exp.bank_en, exp.mem_we, exp.busy, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected outputs for one transaction: GRANT, ACCESS x AC, DONE, then one IDLE cycle.
  task automatic push_txn(input logic [3:0] g, input logic [3:0] b, input logic w);
    sb_q.push_back({g, b, 16'h0000, 1'b0, 1'b1, 4'b0000});
    for (int i = 0; i < AC; i++) sb_q.push_back({g, b, 16'h0001 << b, w, 1'b1, 4'b0000});
    sb_q.push_back({g, b, 16'h0000, 1'b0, 1'b1, g});
    sb_q.push_back({4'b0000, b, 16'h0000, 1'b0, 1'b0, 4'b0000});
  endtask

  task automatic drain(input string name, input int n);
    snap_t exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: scoreboard empty at cycle %0d, want a queued expectation", name, i);
      end else begin
        exp = sb_q.pop_front();
        check(name, snap(), exp);
      end
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    drive(4'b0000, 16'h0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int         en_cnt[3];
    int         done_cnt[3];
    logic [3:0] bv;

    vecs[0] = '{4'b0100, 16'h5A21, 4'b0100, 4'b0100, 4'hA, 1'b1};
    vecs[1] = '{4'b0011, 16'h9E83, 4'b1110, 4'b0001, 4'h3, 1'b0};
    vecs[2] = '{4'b1001, 16'hF123, 4'b1000, 4'b1000, 4'hF, 1'b1};
    vecs[3] = '{4'b0110, 16'h4871, 4'b0100, 4'b0010, 4'h7, 1'b0};
    vecs[4] = '{4'b0010, 16'hBB0B, 4'b0010, 4'b0010, 4'h0, 1'b1};
    vecs[5] = '{4'b1000, 16'hC000, 4'b0111, 4'b1000, 4'hC, 1'b0};

    clr = 1'b1;
    drive(4'b0000, 16'h0000, 4'b0000);
    #2;
    check("reset_state", snap(), '0);
    @(negedge clk);
    clr = 1'b0;

    // Arbitration vectors; ptr evolves 0 -> 3 -> 1 -> 0 -> 2 -> 2 -> 0.
    foreach (vecs[v]) begin
      drive(vecs[v].req, vecs[v].req_bank, vecs[v].req_we);
      push_txn(vecs[v].exp_gnt, vecs[v].exp_bank, vecs[v].exp_we);
      drain($sformatf("vec%0d", v), AC + 3);
    end

    // All four requesting continuously: grants rotate 0,1,2,3,0 back to back.
    drive(4'b1111, 16'h3210, 4'b1010);
    push_txn(4'b0001, 4'h0, 1'b0);
    push_txn(4'b0010, 4'h1, 1'b1);
    push_txn(4'b0100, 4'h2, 1'b0);
    push_txn(4'b1000, 4'h3, 1'b1);
    push_txn(4'b0001, 4'h0, 1'b0);
    drain("contention", 5 * (AC + 3));
    drive(4'b0000, 16'h0000, 4'b0000);

    // Requester 1 drops its request and scrambles its inputs in the first ACCESS cycle.
    drive(4'b0010, 16'h0060, 4'b0010);
    push_txn(4'b0010, 4'h6, 1'b1);
    drain("drop_pre", 2);
    drive(4'b0000, 16'hFFFF, 4'b1111);
    drain("drop_post", AC + 1);

    for (int b = 0; b < 16; b++) begin
      bv = 4'(b);
      drive(4'b0001, {12'h000, bv}, {3'b000, bv[0]});
      push_txn(4'b0001, bv, bv[0]);
      drain($sformatf("bank%0d", b), AC + 3);
    end

    // Clear asserted between edges in the middle of ACCESS: outputs drop at once, no done.
    drive(4'b0100, 16'h0500, 4'b0100);
    push_txn(4'b0100, 4'h5, 1'b1);
    drain("pre_clr", 2);
    sb_q.delete();
    #2;
    clr = 1'b1;
    drive(4'b0000, 16'h0000, 4'b0000);
    #1;
    check("clr_async", snap(), '0);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_after1", snap(), '0);
    @(negedge clk);
    check("clr_no_done", snap(), '0);
    drive(4'b1001, 16'h7006, 4'b0001);
    push_txn(4'b0001, 4'h6, 1'b1);
    drain("post_clr", AC + 3);
    drive(4'b0000, 16'h0000, 4'b0000);

    // ACCESS_CYCLES sweep: count enabled cycles for bank 9 on each instance.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      en_cnt[i]   = 0;
      done_cnt[i] = 0;
    end
    drive(4'b0001, 16'h0009, 4'b0001);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) drive(4'b0000, 16'h0000, 4'b0000);
      if (bus.bank_en   == 16'h0200) en_cnt[0]++;
      if (bus1.bank_en  == 16'h0200) en_cnt[1]++;
      if (bus15.bank_en == 16'h0200) en_cnt[2]++;
      if (bus.done   == 4'b0001) done_cnt[0]++;
      if (bus1.done  == 4'b0001) done_cnt[1]++;
      if (bus15.done == 4'b0001) done_cnt[2]++;
    end
    check_int("en_cycles_ac2",  en_cnt[0], 2);
    check_int("en_cycles_ac1",  en_cnt[1], 1);
    check_int("en_cycles_ac15", en_cnt[2], 15);
    check_int("done_ac1",  done_cnt[1], 1);
    check_int("done_ac15", done_cnt[2], 1);
    check_int("idle_ac15", int'(bus15.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
